// File: rtl/pe_cfg_loader.sv
// pe_cfg_loader: buffers tagged configuration words per PE and, on go,
// releases them to every PE configure channel in lockstep.
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_pe/in_data : config word stream (accepted in LOAD)
//   go      : start release (sampled in LOAD)
//   cfg_out : N_PE channels of {valid, data}, channel i at [i*(DW+1) +: DW+1]
//   busy    : high while releasing
//   done    : one-cycle pulse when a release (or empty go) completes
//   err     : sticky dropped-word flag
module pe_cfg_loader #(
  parameter int N_PE  = 2,
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int PEW   = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PEW-1:0]           in_pe,
  input  logic [DW-1:0]            in_data,
  input  logic                     go,
  output logic [N_PE*(DW+1)-1:0]   cfg_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CH = DW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {LOAD, RELEASE} state_t;

  state_t              state;
  logic [DW-1:0]       mem    [N_PE][DEPTH];
  logic [CW-1:0]       cnt    [N_PE];
  logic [CW-1:0]       cnt_nx [N_PE];
  logic [CW-1:0]       idx;
  logic [CW-1:0]       last;
  logic [CW-1:0]       m_nx;
  logic [N_PE-1:0]     hit;
  logic                wr;
  logic                wr_ok;
  logic [N_PE*CH-1:0]  first_word;

  assign in_ready = (state == LOAD);

  // Word 0 is registered on the go edge itself, so a word written on that
  // same edge into an empty channel is bypassed straight from in_data.
  always_comb begin
    wr         = in_valid & in_ready;
    hit        = '0;
    m_nx       = '0;
    first_word = '0;
    for (int unsigned i = 0; i < N_PE; i++) begin
      hit[i]    = wr && (in_pe == PEW'(i)) && (cnt[i] != FULL);
      cnt_nx[i] = cnt[i] + CW'(hit[i]);
      if (cnt_nx[i] > m_nx)
        m_nx = cnt_nx[i];
      if (cnt_nx[i] != '0)
        first_word[i*CH +: CH] = {1'b1, (cnt[i] == '0) ? in_data : mem[i][0]};
    end
    wr_ok = |hit;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_PE; i++)
      for (int unsigned j = 0; j < DEPTH; j++)
        if (hit[i] && cnt[i] == CW'(j))
          mem[i][j] <= in_data;
  end

  // idx holds the next word index to present; word 0 goes out on the go edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      idx     <= '0;
      last    <= '0;
      cfg_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < N_PE; i++)
        cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (wr && !wr_ok)
            err <= 1'b1;
          for (int unsigned i = 0; i < N_PE; i++)
            cnt[i] <= cnt_nx[i];
          if (go) begin
            if (m_nx != '0) begin
              state   <= RELEASE;
              cfg_out <= first_word;
              busy    <= 1'b1;
              idx     <= CW'(1);
              last    <= m_nx;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (idx == last) begin
            state   <= LOAD;
            cfg_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            for (int unsigned i = 0; i < N_PE; i++)
              cnt[i] <= '0;
          end else begin
            for (int unsigned i = 0; i < N_PE; i++)
              cfg_out[i*CH +: CH] <= (idx < cnt[i]) ? {1'b1, mem[i][idx[AW-1:0]]} : '0;
            idx <= idx + CW'(1);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_cfg_loader.sv
module tb_pe_cfg_loader;

  localparam int N_PE  = 2;
  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int PEW   = 2;
  localparam int CH    = DW + 1;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [PEW-1:0]          in_pe = '0;
  logic [DW-1:0]           in_data = '0;
  logic                    go = 1'b0;
  logic [N_PE*CH-1:0]      cfg_out;
  logic                    busy;
  logic                    done;
  logic                    err;

  pe_cfg_loader #(.N_PE(N_PE), .DEPTH(DEPTH), .DW(DW), .PEW(PEW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pe(in_pe), .in_data(in_data), .go(go), .cfg_out(cfg_out),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_PE*CH-1:0] cfg;
    logic               busy;
    logic               done;
  } exp_t;

  exp_t        exp_q[$];
  logic [DW-1:0] mw [N_PE][DEPTH];
  int          mcnt [N_PE];
  logic        merr;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N_PE*CH-1:0] exp_cfg(input int k);
    logic [N_PE*CH-1:0] v;
    v = '0;
    for (int ch = 0; ch < N_PE; ch++)
      if (k < mcnt[ch])
        v[ch*CH +: CH] = {1'b1, mw[ch][k]};
    return v;
  endfunction

  task automatic model_wr(input int pe, input logic [DW-1:0] data);
    if (pe < N_PE && mcnt[pe] < DEPTH) begin
      mw[pe][mcnt[pe]] = data;
      mcnt[pe]++;
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < N_PE; ch++) mcnt[ch] = 0;
  endtask

  task automatic wr(input int pe, input logic [DW-1:0] data);
    @(negedge clk);
    check("in_ready_wr", in_ready, 1'b1);
    in_valid = 1'b1;
    in_pe    = PEW'(pe);
    in_data  = data;
    model_wr(pe, data);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_go(input bit with_wr, input int pe, input logic [DW-1:0] data);
    int   m;
    exp_t e;
    @(negedge clk);
    go = 1'b1;
    if (with_wr) begin
      in_valid = 1'b1;
      in_pe    = PEW'(pe);
      in_data  = data;
      model_wr(pe, data);
    end
    m = 0;
    for (int ch = 0; ch < N_PE; ch++) if (mcnt[ch] > m) m = mcnt[ch];
    for (int k = 0; k < m; k++) begin
      e.cfg = exp_cfg(k); e.busy = 1'b1; e.done = 1'b0;
      exp_q.push_back(e);
    end
    e.cfg = '0; e.busy = 1'b0; e.done = 1'b1; exp_q.push_back(e);
    e.cfg = '0; e.busy = 1'b0; e.done = 1'b0; exp_q.push_back(e);
    model_clear();
    @(posedge clk);
    #1;
    go       = 1'b0;
    in_valid = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cfg_out", cfg_out, e.cfg);
      check("busy", busy, e.busy);
      check("done", done, e.done);
      check("in_ready", in_ready, !e.busy);
      if (exp_q.size() > 0) begin
        @(posedge clk);
        #1;
      end
    end
    check("err", err, merr);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    merr = 1'b0;
    model_clear();
  endtask

  logic [N_PE*CH-1:0] c1, c2;

  initial begin
    merr = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_out", cfg_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b1;

    // Basic lockstep release with unequal channel depths
    wr(0, 32'hDEAD_BEEF); wr(0, 32'd0); wr(0, 32'd100);
    wr(1, 32'h1234_5678); wr(1, 32'd1);
    do_go(0, 0, '0);

    // Empty go: done only
    do_go(0, 0, '0);

    // Reset during the second release cycle
    wr(0, 32'hDEAD_BEEF); wr(0, 32'd0); wr(0, 32'd100);
    wr(1, 32'h1234_5678); wr(1, 32'd1);
    c1 = exp_cfg(0);
    c2 = exp_cfg(1);
    model_clear();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    check("mid_c1", cfg_out, c1);
    @(posedge clk);
    #1 check("mid_c2", cfg_out, c2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cfg", cfg_out, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1 check("mid_rst_no_done", done, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    merr = 1'b0;
    do_go(0, 0, '0);

    // Out-of-range PE index is dropped
    wr(0, 32'hA5A5_0001);
    check("bad_pe_err_before", err, 1'b0);
    wr(3, 32'hBAD0_BAD0);
    #1 check("bad_pe_err_after", err, 1'b1);
    do_go(0, 0, '0);

    // Overflow: fifth word to PE0 is dropped
    pulse_reset();
    #1 check("ovf_err_cleared", err, 1'b0);
    for (int i = 0; i < 4; i++) wr(0, 32'h1000_0000 + i);
    #1 check("ovf_err_4", err, 1'b0);
    wr(0, 32'h1000_0004);
    #1 check("ovf_err_5", err, 1'b1);
    do_go(0, 0, '0);

    // Write and go on the same edge
    pulse_reset();
    wr(1, 32'h0000_BEEF);
    do_go(1, 0, 32'hCAFE_0000);

    // Randomised loads
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(0, 7);
      for (int j = 0; j < n; j++) wr($urandom_range(0, 3), $urandom);
      do_go($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
